zero_share_arb: RTL and testbench

- Round-robin arbiter/sequencer that shares one W-bit zero detector (NOR-reduce of all operand bits) among 4 requesters.
- Each requester presents a word and raises req. The block grants one requester, latches its word, evaluates it through the detector, and returns a per-requester ack with the registered result.
- Keeps a saturating count of zero results for status.
- Sits between operand sources (register bank / test drivers) and the shared zero-detect datapath.

---
 rtl/zero_share_arb.sv | 131 +++++++++++++
 tb/tb_zero_share_arb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/zero_share_arb.sv
// Round-robin arbiter that shares one W-bit zero detector among four requesters.
// Each grant latches the winner's operand, registers the detector result, then pulses ack/valid.
module zero_share_arb #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    req,
  input  logic [W-1:0]  data0,
  input  logic [W-1:0]  data1,
  input  logic [W-1:0]  data2,
  input  logic [W-1:0]  data3,
  input  logic          clr_cnt,
  output logic [3:0]    ack,
  output logic          valid,
  output logic          zero,
  output logic [1:0]    id,
  output logic          busy,
  output logic [CW-1:0] zero_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    gid;
  logic [W-1:0]  opnd;
  logic          zres;

  logic          pick_vld;
  logic [1:0]    pick_idx;
  logic [1:0]    cand;
  logic [W-1:0]  pick_data;
  logic          opnd_zero;
  logic          cnt_max;

  // Rotating priority scan: walk offsets from farthest to nearest so the
  // requester closest to ptr is the last (and therefore winning) assignment.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    pick_vld = 1'b0;
    pick_idx = ptr;
    cand     = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    pick_data = data0;
    case (pick_idx)
      2'd0:    pick_data = data0;
      2'd1:    pick_data = data1;
      2'd2:    pick_data = data2;
      default: pick_data = data3;
    endcase
  end

  // The shared detector: a plain NOR-reduce of the latched operand.
  assign opnd_zero = ~|opnd;
  assign cnt_max   = (zero_cnt == {CW{1'b1}});

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples pre-edge values; all registers, including the operand latch, are
  // cleared by reset so an aborted transaction leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 2'd0;
      gid   <= 2'd0;
      opnd  <= '0;
      zres  <= 1'b0;
      ack   <= 4'b0000;
      valid <= 1'b0;
      zero  <= 1'b0;
      id    <= 2'd0;
      busy  <= 1'b0;
    end else begin
      ack   <= 4'b0000;
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            opnd  <= pick_data;
            gid   <= pick_idx;
            busy  <= 1'b1;
            state <= EVAL;
          end
        end
        EVAL: begin
          zres  <= opnd_zero;
          state <= RESP;
        end
        RESP: begin
          ack   <= 4'b0001 << gid;
          valid <= 1'b1;
          zero  <= zres;
          id    <= gid;
          ptr   <= gid + 2'd1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Clear has priority over a coincident increment; the count never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_cnt <= '0;
    end else if (clr_cnt) begin
      zero_cnt <= '0;
    end else if (state == RESP && zres && !cnt_max) begin
      zero_cnt <= zero_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_zero_share_arb.sv
// Directed and randomized checks of zero_share_arb against a transaction-level model.
module tb_zero_share_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [7:0] dv [4];
  logic       clr_cnt;
  logic [3:0] ack;
  logic       valid;
  logic       zero;
  logic [1:0] id;
  logic       busy;
  logic [7:0] zero_cnt;

  int total = 0;
  int bad   = 0;

  // Model state: rotating pointer, counter, last reported result.
  int       ptr_m;
  int       cnt_m;
  int       last_id_m;
  logic     last_zero_m;

  zero_share_arb #(.W(8), .CW(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data0    (dv[0]),
    .data1    (dv[1]),
    .data2    (dv[2]),
    .data3    (dv[3]),
    .clr_cnt  (clr_cnt),
    .ack      (ack),
    .valid    (valid),
    .zero     (zero),
    .id       (id),
    .busy     (busy),
    .zero_cnt (zero_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ptr_m       = 0;
    cnt_m       = 0;
    last_id_m   = 0;
    last_zero_m = 1'b0;
  endtask

  // One full transaction starting from IDLE; returns just after the ack edge.
  task automatic txn(input logic [3:0] r, input bit drop, input bit chg,
                     input bit clr_resp, input string tag);
    int   exp_id;
    logic exp_zero;
    req      = r;
    exp_id   = pick(r, ptr_m);
    exp_zero = (dv[exp_id] == 8'h00);
    @(posedge clk); #1;                       // grant edge
    check({tag, ".eval_busy"}, busy, 1);
    check({tag, ".eval_ack"}, {valid, ack}, 0);
    check({tag, ".eval_hold"}, {zero, id}, {last_zero_m, 2'(last_id_m)});
    if (drop) req = 4'b0000;
    if (chg)  dv[exp_id] = ~dv[exp_id];
    @(posedge clk); #1;                       // into RESP
    check({tag, ".resp_busy"}, busy, 1);
    check({tag, ".resp_ack"}, {valid, ack}, 0);
    if (clr_resp) clr_cnt = 1'b1;
    @(posedge clk); #1;                       // ack cycle
    clr_cnt = 1'b0;
    if (clr_resp)      cnt_m = 0;
    else if (exp_zero) cnt_m = (cnt_m < 255) ? cnt_m + 1 : 255;
    ptr_m       = (exp_id + 1) % 4;
    last_id_m   = exp_id;
    last_zero_m = exp_zero;
    check({tag, ".ack"}, ack, 32'(1) << exp_id);
    check({tag, ".valid"}, valid, 1);
    check({tag, ".zero"}, zero, exp_zero);
    check({tag, ".id"}, id, exp_id);
    check({tag, ".busy_low"}, busy, 0);
    check({tag, ".cnt"}, zero_cnt, cnt_m);
  endtask

  initial begin
    reset   = 1'b1;
    req     = 4'b0000;
    clr_cnt = 1'b0;
    for (int i = 0; i < 4; i++) dv[i] = 8'hA5;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.outs", {ack, valid, zero, id, busy}, 0);
    check("rst.cnt", zero_cnt, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle.noack", {valid, ack, busy}, 0);

    // Single zero request from requester 0.
    dv[0] = 8'h00;
    txn(4'b0001, 1'b1, 1'b0, 1'b0, "single0");
    check("single0.cnt_is_1", zero_cnt, 1);

    // Non-zero operands from requesters 2 and 3.
    dv[2] = 8'h80; txn(4'b0100, 1'b1, 1'b0, 1'b0, "nz80");
    dv[2] = 8'h01; txn(4'b0100, 1'b1, 1'b0, 1'b0, "nz01");
    dv[2] = 8'hFF; txn(4'b0100, 1'b1, 1'b0, 1'b0, "nzFF");
    dv[3] = 8'h40; txn(4'b1000, 1'b1, 1'b0, 1'b0, "nz40");
    check("nz.cnt_unchanged", zero_cnt, 1);

    // All four requesting: service must rotate 0,1,2,3,0.
    dv[0] = 8'h00; dv[1] = 8'h01; dv[2] = 8'h00; dv[3] = 8'h10;
    for (int n = 0; n < 5; n++) begin
      txn(4'b1111, 1'b0, 1'b0, 1'b0, $sformatf("rr%0d", n));
      check($sformatf("rr%0d.order", n), id, n % 4);
    end
    req = 4'b0000;
    check("rr.cnt", zero_cnt, 4);

    // Operand changed after grant, and req dropped during EVAL.
    dv[1] = 8'h00;
    txn(4'b0010, 1'b1, 1'b1, 1'b0, "chg_after_grant");
    check("chg_after_grant.zero_is_1", zero, 1);

    // Saturation: clear, then 256 zero results.
    @(posedge clk); #1;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    cnt_m = 0;
    check("clr.idle", zero_cnt, 0);
    dv[0] = 8'h00;
    for (int n = 0; n < 256; n++) txn(4'b0001, 1'b1, 1'b0, 1'b0, "sat");
    check("sat.cap", zero_cnt, 255);
    txn(4'b0001, 1'b1, 1'b0, 1'b1, "clr_on_resp");
    check("clr_on_resp.zero", zero_cnt, 0);

    // Asynchronous reset between edges while in EVAL.
    dv[0] = 8'h00;
    req = 4'b0001;
    @(posedge clk); #1;
    check("abort.in_eval", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("abort.outs", {ack, valid, zero, id, busy}, 0);
    check("abort.cnt", zero_cnt, 0);
    req = 4'b0000;
    @(posedge clk); #1;
    check("abort.held", {ack, valid, busy}, 0);
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("abort.no_ack", {ack, valid}, 0);
    dv[1] = 8'h33;
    txn(4'b0010, 1'b1, 1'b0, 1'b0, "post_reset");
    check("post_reset.id", id, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      logic [3:0] r;
      r = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++)
        dv[i] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      txn(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) == 0), $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) begin
        req = 4'b0000;
        @(posedge clk); #1;
        check($sformatf("rnd%0d.idle", n), {ack, valid, busy}, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
